// File: rtl/fmap_stream_source_pkg.sv
// fmap_stream_source_pkg: shared FSM encodings and source pipeline latency
package fmap_stream_source_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam int SRC_LATENCY = 2;
endpackage

// File: rtl/fmap_stream_source_if.sv
// fmap_stream_source_if: control, memory-read and pixel-stream signals of the feature-map source
interface fmap_stream_source_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic start;
  logic pause;
  logic mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] data_out;
  logic data_valid_out;
  logic busy;
  logic done;
  modport master (
    input start, pause, mem_data,
    output mem_en, mem_addr, data_out, data_valid_out, busy, done
  );
  modport slave (
    output start, pause, mem_data,
    input mem_en, mem_addr, data_out, data_valid_out, busy, done
  );
endinterface

// File: rtl/fmap_stream_source_pixel_pos_counter.sv
// pixel_pos_counter: row-major col/row walker over a WxH grid; border flag when ZERO_PAD_EN is defined
module pixel_pos_counter #(
  parameter int W  = 4,
  parameter int H  = 3,
  parameter int CW = $clog2(W + 1),
  parameter int RW = $clog2(H + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic advance,
  input  logic clear,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
`ifdef ZERO_PAD_EN
  output logic border,
`endif
  output logic last
);
  logic col_end;
  assign col_end = col == CW'(W - 1);
  assign last = col_end && row == RW'(H - 1);
`ifdef ZERO_PAD_EN
  assign border = col == '0 || col_end || row == '0 || row == RW'(H - 1);
`endif
  // step one position per advance; col wraps into row, final position wraps to origin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      col <= col_end ? '0 : col + 1'b1;
      row <= !col_end ? row : last ? '0 : row + 1'b1;
    end
  end
endmodule

// File: rtl/fmap_stream_source.sv
// fmap_stream_source: streams a stored feature map row-major from sync RAM (optional zero border via ZERO_PAD_EN)
module fmap_stream_source
  import fmap_stream_source_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int ADDR_WIDTH = 10
) (
  input logic CLK,
  input logic RST,
  fmap_stream_source_if.master bus
);
`ifdef ZERO_PAD_EN
  localparam int GW = IMG_WIDTH + 2;
  localparam int GH = IMG_HEIGHT + 2;
`else
  localparam int GW = IMG_WIDTH;
  localparam int GH = IMG_HEIGHT;
`endif
  localparam int CW = $clog2(GW + 1);
  localparam int RW = $clog2(GH + 1);
  logic [1:0] state;
  logic issue, last, start_acc, v1, l1;
  logic [CW-1:0] col_unused;
  logic [RW-1:0] row_unused;
  logic [DATA_WIDTH-1:0] pix;
  assign start_acc = state == IDLE && bus.start;
  assign issue = state == ISSUE && !bus.pause;
  assign bus.busy = state != IDLE;
`ifdef ZERO_PAD_EN
  logic border, pad1;
  assign bus.mem_en = issue && !border;
  assign pix = pad1 ? '0 : bus.mem_data;
`else
  assign bus.mem_en = issue;
  assign pix = bus.mem_data;
`endif
  pixel_pos_counter #(.W(GW), .H(GH), .CW(CW), .RW(RW)) u_pos (
    .clk(CLK),
    .rst(RST),
    .advance(issue),
    .clear(start_acc),
    .col(col_unused),
    .row(row_unused),
`ifdef ZERO_PAD_EN
    .border(border),
`endif
    .last(last)
  );
  // frame control: IDLE -> ISSUE on start, -> DRAIN after final issue, -> IDLE after done
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else state <= state == IDLE  ? (bus.start ? ISSUE : IDLE) :
                  state == ISSUE ? (issue && last ? DRAIN : ISSUE) :
                  state == DRAIN ? (bus.done ? IDLE : DRAIN) : IDLE;
  end
  // linear read address, held on the final position so it stays put while draining
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) bus.mem_addr <= '0;
    else if (start_acc) bus.mem_addr <= '0;
    else if (bus.mem_en && !last) bus.mem_addr <= bus.mem_addr + 1'b1;
  end
  // two-stage token pipeline: stage 1 aligns with RAM data, stage 2 registers the pixel
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v1 <= 1'b0;
      l1 <= 1'b0;
      bus.data_out <= '0;
      bus.data_valid_out <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      v1 <= issue;
      l1 <= issue && last;
      bus.data_valid_out <= v1;
      bus.done <= l1;
      if (v1) bus.data_out <= pix;
    end
  end
`ifdef ZERO_PAD_EN
  // border tokens carry a pad flag alongside the valid bit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pad1 <= 1'b0;
    else pad1 <= issue && border;
  end
`endif
endmodule

// File: tb/tb_fmap_stream_source.sv
// tb_fmap_stream_source: directed self-checking bench (4x3 frame, or 2x2 padded frame with ZERO_PAD_EN)
module tb_fmap_stream_source;
`ifdef ZERO_PAD_EN
  localparam int W = 2, H = 2;
`else
  localparam int W = 4, H = 3;
`endif
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int tests = 0, fails = 0;
  logic [15:0] mem [0:15];
  always #5 CLK = ~CLK;
  fmap_stream_source_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) bus ();
  fmap_stream_source #(.DATA_WIDTH(16), .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(10)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );
  always @(posedge CLK) if (bus.mem_en) bus.mem_data <= mem[bus.mem_addr[3:0]];
  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle %0d: got %0h expected %0h", tag, c, obs, exp);
    end
  endtask
  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.busy && n < 60) begin nxt(); n++; end
    chk(tag, n, {31'd0, bus.busy}, 0);
    nxt();
  endtask
  initial begin
    int idx, cnt;
`ifdef ZERO_PAD_EN
    int pad_exp [16] = '{0,0,0,0, 0,1,2,0, 0,3,4,0, 0,0,0,0};
    int en_addr [4] = '{0,0,0,0};
    for (int i = 0; i < 16; i++) mem[i] = 16'(i + 1);
`else
    for (int i = 0; i < 16; i++) mem[i] = 16'(i + 100);
`endif
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.mem_data = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_mem_en", 0, {31'd0, bus.mem_en}, 0);
    chk("rst_addr", 0, 32'(bus.mem_addr), 0);
    chk("rst_valid", 0, {31'd0, bus.data_valid_out}, 0);
    chk("rst_data", 0, 32'(bus.data_out), 0);
    chk("rst_busy", 0, {31'd0, bus.busy}, 0);
    chk("rst_done", 0, {31'd0, bus.done}, 0);
    nxt();
    RST = 1'b0;
    nxt();
`ifdef ZERO_PAD_EN
    idx = 0;
    cnt = 0;
    for (int c = 0; c <= 20; c++) begin
      bus.start = c == 0;
      @(negedge CLK);
      if (bus.mem_en) begin
        if (cnt < 4) en_addr[cnt] = int'(bus.mem_addr);
        cnt++;
      end
      chk("pad_valid", c, {31'd0, bus.data_valid_out}, (c >= 3 && c <= 18) ? 1 : 0);
      if (bus.data_valid_out && idx < 16) begin
        chk("pad_data", c, 32'(bus.data_out), pad_exp[idx]);
        idx++;
      end
      chk("pad_done", c, {31'd0, bus.done}, c == 18 ? 1 : 0);
      nxt();
    end
    chk("pad_pixels", 0, idx, 16);
    chk("pad_reads", 0, cnt, 4);
    for (int i = 0; i < 4; i++) chk("pad_addr", i, en_addr[i], i);
`else
    for (int c = 0; c <= 16; c++) begin
      bus.start = c == 0;
      @(negedge CLK);
      chk("t1_en", c, {31'd0, bus.mem_en}, (c >= 1 && c <= 12) ? 1 : 0);
      if (c >= 1 && c <= 12) chk("t1_addr", c, 32'(bus.mem_addr), c - 1);
      chk("t1_valid", c, {31'd0, bus.data_valid_out}, (c >= 3 && c <= 14) ? 1 : 0);
      if (c >= 3 && c <= 14) chk("t1_data", c, 32'(bus.data_out), c + 97);
      chk("t1_done", c, {31'd0, bus.done}, c == 14 ? 1 : 0);
      chk("t1_busy", c, {31'd0, bus.busy}, (c >= 1 && c <= 14) ? 1 : 0);
      nxt();
    end
    idx = 0;
    for (int c = 0; c <= 19; c++) begin
      bus.start = c == 0;
      bus.pause = c >= 5 && c <= 7;
      @(negedge CLK);
      chk("t2_en", c, {31'd0, bus.mem_en}, ((c >= 1 && c <= 4) || (c >= 8 && c <= 15)) ? 1 : 0);
      if ((c >= 1 && c <= 4) || (c >= 8 && c <= 15)) chk("t2_addr", c, 32'(bus.mem_addr), c <= 4 ? c - 1 : c - 4);
      chk("t2_valid", c, {31'd0, bus.data_valid_out}, ((c >= 3 && c <= 6) || (c >= 10 && c <= 17)) ? 1 : 0);
      if (bus.data_valid_out) begin
        chk("t2_data", c, 32'(bus.data_out), 100 + idx);
        idx++;
      end
      chk("t2_done", c, {31'd0, bus.done}, c == 17 ? 1 : 0);
      chk("t2_busy", c, {31'd0, bus.busy}, (c >= 1 && c <= 17) ? 1 : 0);
      nxt();
    end
    bus.pause = 1'b0;
    chk("t2_pixels", 0, idx, 12);
    cnt = 0;
    for (int c = 0; c <= 16; c++) begin
      bus.start = c == 0 || c == 6 || c == 14 || c == 15;
      @(negedge CLK);
      if (bus.data_valid_out) cnt++;
      if (c == 14) chk("t3_done", c, {31'd0, bus.done}, 1);
      if (c == 16) begin
        chk("t3_restart_en", c, {31'd0, bus.mem_en}, 1);
        chk("t3_restart_addr", c, 32'(bus.mem_addr), 0);
      end
      nxt();
    end
    bus.start = 1'b0;
    chk("t3_pixels", 0, cnt, 12);
    wait_idle("t3_idle_timeout");
    for (int c = 0; c <= 8; c++) begin
      bus.start = c == 0;
      if (c == 8) begin
        @(negedge CLK);
        chk("t4_pre_en", c, {31'd0, bus.mem_en}, 1);
        chk("t4_pre_valid", c, {31'd0, bus.data_valid_out}, 1);
        #1 RST = 1'b1;
        #1;
        chk("t4_en", c, {31'd0, bus.mem_en}, 0);
        chk("t4_valid", c, {31'd0, bus.data_valid_out}, 0);
        chk("t4_busy", c, {31'd0, bus.busy}, 0);
        chk("t4_done", c, {31'd0, bus.done}, 0);
      end
      nxt();
    end
    RST = 1'b0;
    nxt();
    bus.start = 1'b1;
    nxt();
    bus.start = 1'b0;
    @(negedge CLK);
    chk("t4_restart_en", 1, {31'd0, bus.mem_en}, 1);
    chk("t4_restart_addr", 1, 32'(bus.mem_addr), 0);
    chk("t4_restart_busy", 1, {31'd0, bus.busy}, 1);
    nxt();
    wait_idle("t4_idle_timeout");
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
